onchip_memory_arb: RTL and testbench
====================================

ONCHIP_MEMORY_ARB -- requirements
Module: onchip_memory_arb

Interface
REQ-001 Parameter DATA_W, default 32, data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 13, word-address width.
REQ-003 Parameter DEPTH, default 6500, number of words; SHALL satisfy DEPTH <= 2**ADDR_W.
REQ-004 Parameter OUT_REG, default 0, read latency select: 0 gives 1 cycle, 1 gives 2 cycles.
REQ-005 Parameter INIT_FILE, default "onchip_memory_arb.hex", memory initialisation file.
REQ-006 Derived constant BE_W = DATA_W/8, byteenable width.
REQ-007 clk  in  1  sole clock; all state on rising edge.
REQ-008 reset_n  in  1  reset, asynchronous, active-low.
REQ-009 clken  in  1  global clock enable; low freezes all state.
REQ-010 For p in {a,b}, p_address  in  ADDR_W  word address.
REQ-011 p_byteenable  in  BE_W  write byte lanes.
REQ-012 p_chipselect  in  1  request qualifier.
REQ-013 p_read / p_write  in  1 each  command; both high in one cycle is illegal.
REQ-014 p_writedata  in  DATA_W  write data.
REQ-015 p_waitrequest  out  1  command not accepted this cycle.
REQ-016 p_readdata  out  DATA_W  read data, valid only with p_readdatavalid.
REQ-017 p_readdatavalid  out  1  one-cycle pulse per accepted read.

Function
REQ-018 A request on port p SHALL be chipselect & (read | write); it is accepted in a cycle where it is asserted and p_waitrequest is low.
REQ-019 The array SHALL be single-ported: at most one access, read or write, is accepted per cycle.
REQ-020 Arbitration SHALL be two-way round-robin: a single requester wins; with both requesting, the port named by grant pointer wins and the pointer then moves to the other port.
REQ-021 The grant pointer SHALL update only on an accepted access under simultaneous request; an uncontested access leaves it unchanged.
REQ-022 p_waitrequest SHALL be combinational: high when p requests and loses arbitration or clken is low; low otherwise.
REQ-023 Accepted write SHALL update only bytes whose byteenable bit is 1; byteenable all-zero is accepted as a no-op.
REQ-024 Accepted read SHALL raise p_readdatavalid exactly 1 (OUT_REG=0) or 2 (OUT_REG=1) enabled cycles later, with p_readdata from that port only.
REQ-025 Reads SHALL be fully pipelined: back-to-back reads return back-to-back valids in acceptance order.
REQ-026 A read accepted the cycle after a write to the same address SHALL return the newly written data.
REQ-027 Address >= DEPTH: write SHALL be discarded, read SHALL return all-zero with normal valid timing.
REQ-028 clken low SHALL hold the read pipeline, grant pointer and outputs; pending valids resume when clken returns high, and no valid is lost or duplicated.
REQ-029 p_readdata SHALL hold its last value while p_readdatavalid is low.

Reset
REQ-030 On reset_n low, asynchronously: both readdatavalid 0, both readdata 0, read pipeline emptied, grant pointer = port a.
REQ-031 Reads in flight at reset SHALL be dropped without a valid pulse.
REQ-032 Memory contents SHALL NOT be cleared by reset; INIT_FILE contents apply only at configuration.
REQ-033 Reset deassertion SHALL be accepted on any edge; first accept possible the first clk edge after release.

Structure
REQ-034 Package onchip_mem_pkg SHALL hold the port-select enum (PORT_A, PORT_B) and the latency constants for OUT_REG 0/1.
REQ-035 Sub-module onchip_mem_rr_arb SHALL implement the two-way round-robin arbiter and grant pointer; storage and read pipeline stay in the top level.
REQ-036 Storage SHALL be an inferred array with per-byte write enables, mappable to block RAM.

Verification
REQ-037 Reset, a writes 0xDEADBEEF to 0x010 BE=1111, a reads 0x010 -> readdatavalid_a one cycle later, readdata_a=0xDEADBEEF; b sees no valid.
REQ-038 Both ports read same cycle after reset -> waitrequest_b=1, a served first, b served next cycle; third simultaneous pair -> a served again.
REQ-039 Word 0x020=0x11223344, write 0xAABBCCDD BE=0101, read -> 0x11BB33DD.
REQ-040 OUT_REG=1, four back-to-back reads from a of 0..3 -> four consecutive valids, cycles 2..5, data in order.
REQ-041 Read address 6500 -> valid with 0x00000000; write to 6600 then read 6600-DEPTH-aliased address 100 unchanged.
REQ-042 Read accepted, clken low 3 cycles, then high -> exactly one valid, after clken returns; repeat with reset_n pulsed mid-flight -> no valid, grant pointer = a.

Source files
------------

// File: rtl/onchip_mem_pkg.sv
// Shared types and constants for the arbitrated single-port on-chip memory.
package onchip_mem_pkg;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_sel_e;

  localparam int unsigned RD_LAT_OUTREG0 = 1;
  localparam int unsigned RD_LAT_OUTREG1 = 2;

endpackage

// File: rtl/onchip_mem_rr_arb.sv
// Two-way round-robin arbiter; the pointer flips only when both ports contend.
module onchip_mem_rr_arb
  import onchip_mem_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic clken,
  input  logic req_a_i,
  input  logic req_b_i,
  output logic gnt_a_o,
  output logic gnt_b_o
);

  port_sel_e ptr_q;
  port_sel_e ptr_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= PORT_A;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (clken && req_a_i && req_b_i) begin
      ptr_d = (ptr_q == PORT_A) ? PORT_B : PORT_A;
    end
  end

  assign gnt_a_o = clken & req_a_i & (~req_b_i | (ptr_q == PORT_A));
  assign gnt_b_o = clken & req_b_i & (~req_a_i | (ptr_q == PORT_B));

endmodule

// File: rtl/onchip_memory_arb.sv
// Single-port byte-writable RAM shared by two request ports through a
// round-robin arbiter, with a pipelined read path of 1 or 2 cycles.
module onchip_memory_arb
  import onchip_mem_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 13,
  parameter int DEPTH     = 6500,
  parameter int OUT_REG   = 0,
  parameter     INIT_FILE = "onchip_memory_arb.hex"
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clken,
  input  logic [ADDR_W-1:0]     a_address,
  input  logic [DATA_W/8-1:0]   a_byteenable,
  input  logic                  a_chipselect,
  input  logic                  a_read,
  input  logic                  a_write,
  input  logic [DATA_W-1:0]     a_writedata,
  output logic                  a_waitrequest,
  output logic [DATA_W-1:0]     a_readdata,
  output logic                  a_readdatavalid,
  input  logic [ADDR_W-1:0]     b_address,
  input  logic [DATA_W/8-1:0]   b_byteenable,
  input  logic                  b_chipselect,
  input  logic                  b_read,
  input  logic                  b_write,
  input  logic [DATA_W-1:0]     b_writedata,
  output logic                  b_waitrequest,
  output logic [DATA_W-1:0]     b_readdata,
  output logic                  b_readdatavalid
);

  localparam int          BE_W   = DATA_W / 8;
  localparam int unsigned RD_LAT = (OUT_REG != 0) ? RD_LAT_OUTREG1 : RD_LAT_OUTREG0;

  // Preload comes from INIT_FILE through the RAM configuration flow, not from logic.
  if (INIT_FILE != "") begin : g_init_file
  end

  logic req_a;
  logic req_b;
  logic gnt_a;
  logic gnt_b;

  assign req_a = a_chipselect & (a_read | a_write);
  assign req_b = b_chipselect & (b_read | b_write);

  onchip_mem_rr_arb u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .clken   (clken),
    .req_a_i (req_a),
    .req_b_i (req_b),
    .gnt_a_o (gnt_a),
    .gnt_b_o (gnt_b)
  );

  assign a_waitrequest = ~clken | (req_a & ~gnt_a);
  assign b_waitrequest = ~clken | (req_b & ~gnt_b);

  logic              acc_rd;
  logic              acc_wr;
  port_sel_e         acc_port;
  logic [ADDR_W-1:0] acc_addr;
  logic [BE_W-1:0]   acc_be;
  logic [DATA_W-1:0] acc_wdata;
  logic              in_range;

  assign acc_rd    = (gnt_a & a_read)  | (gnt_b & b_read);
  assign acc_wr    = (gnt_a & a_write) | (gnt_b & b_write);
  assign acc_port  = gnt_b ? PORT_B : PORT_A;
  assign acc_addr  = gnt_b ? b_address : a_address;
  assign acc_be    = gnt_b ? b_byteenable : a_byteenable;
  assign acc_wdata = gnt_b ? b_writedata : a_writedata;
  assign in_range  = (32'(acc_addr) < 32'(DEPTH));

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] ram_q;

  always_ff @(posedge clk) begin
    if (clken && acc_wr && in_range) begin
      for (int i = 0; i < BE_W; i++) begin
        if (acc_be[i]) mem_q[acc_addr][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
    if (clken && acc_rd) ram_q <= mem_q[acc_addr];
  end

  // Read stage 1: RAM output register plus its control tag.
  logic              vld_p1_q;
  port_sel_e         port_p1_q;
  logic              oor_p1_q;
  logic [DATA_W-1:0] rd_data_p1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1_q  <= 1'b0;
      port_p1_q <= PORT_A;
      oor_p1_q  <= 1'b0;
    end else if (clken) begin
      vld_p1_q  <= acc_rd;
      port_p1_q <= acc_port;
      oor_p1_q  <= ~in_range;
    end
  end

  assign rd_data_p1 = oor_p1_q ? '0 : ram_q;

  logic              fin_vld;
  port_sel_e         fin_port;
  logic [DATA_W-1:0] fin_data;

  if (RD_LAT == RD_LAT_OUTREG1) begin : g_out_reg
    // Read stage 2: optional output register.
    logic              vld_p2_q;
    port_sel_e         port_p2_q;
    logic [DATA_W-1:0] data_p2_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        vld_p2_q  <= 1'b0;
        port_p2_q <= PORT_A;
      end else if (clken) begin
        vld_p2_q  <= vld_p1_q;
        port_p2_q <= port_p1_q;
      end
    end

    always_ff @(posedge clk) begin
      if (clken) data_p2_q <= rd_data_p1;
    end

    assign fin_vld  = vld_p2_q;
    assign fin_port = port_p2_q;
    assign fin_data = data_p2_q;
  end else begin : g_no_out_reg
    assign fin_vld  = vld_p1_q;
    assign fin_port = port_p1_q;
    assign fin_data = rd_data_p1;
  end

  // A valid is only presented in enabled cycles so a frozen pipeline never repeats it.
  logic              a_vld;
  logic              b_vld;
  logic [DATA_W-1:0] a_last_q;
  logic [DATA_W-1:0] b_last_q;

  assign a_vld = clken & fin_vld & (fin_port == PORT_A);
  assign b_vld = clken & fin_vld & (fin_port == PORT_B);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_last_q <= '0;
      b_last_q <= '0;
    end else begin
      if (a_vld) a_last_q <= fin_data;
      if (b_vld) b_last_q <= fin_data;
    end
  end

  assign a_readdatavalid = a_vld;
  assign b_readdatavalid = b_vld;
  assign a_readdata      = a_vld ? fin_data : a_last_q;
  assign b_readdata      = b_vld ? fin_data : b_last_q;

endmodule

// File: tb/tb_onchip_memory_arb.sv
// Directed bench for onchip_memory_arb: one instance per read latency, shared stimulus.
module tb_onchip_memory_arb;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 13;
  localparam int BE_W   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n;
  logic              clken;
  logic [ADDR_W-1:0] a_address, b_address;
  logic [BE_W-1:0]   a_byteenable, b_byteenable;
  logic              a_chipselect, b_chipselect;
  logic              a_read, a_write, b_read, b_write;
  logic [DATA_W-1:0] a_writedata, b_writedata;

  logic              a_wait0, b_wait0, a_vld0, b_vld0;
  logic [DATA_W-1:0] a_rd0, b_rd0;
  logic              a_wait1, b_wait1, a_vld1, b_vld1;
  logic [DATA_W-1:0] a_rd1, b_rd1;

  onchip_memory_arb #(.OUT_REG(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .clken(clken),
    .a_address(a_address), .a_byteenable(a_byteenable), .a_chipselect(a_chipselect),
    .a_read(a_read), .a_write(a_write), .a_writedata(a_writedata),
    .a_waitrequest(a_wait0), .a_readdata(a_rd0), .a_readdatavalid(a_vld0),
    .b_address(b_address), .b_byteenable(b_byteenable), .b_chipselect(b_chipselect),
    .b_read(b_read), .b_write(b_write), .b_writedata(b_writedata),
    .b_waitrequest(b_wait0), .b_readdata(b_rd0), .b_readdatavalid(b_vld0)
  );

  onchip_memory_arb #(.OUT_REG(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .clken(clken),
    .a_address(a_address), .a_byteenable(a_byteenable), .a_chipselect(a_chipselect),
    .a_read(a_read), .a_write(a_write), .a_writedata(a_writedata),
    .a_waitrequest(a_wait1), .a_readdata(a_rd1), .a_readdatavalid(a_vld1),
    .b_address(b_address), .b_byteenable(b_byteenable), .b_chipselect(b_chipselect),
    .b_read(b_read), .b_write(b_write), .b_writedata(b_writedata),
    .b_waitrequest(b_wait1), .b_readdata(b_rd1), .b_readdatavalid(b_vld1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ar, input logic aw, input logic [ADDR_W-1:0] aa,
                       input logic [BE_W-1:0] abe, input logic [31:0] awd,
                       input logic br, input logic bw, input logic [ADDR_W-1:0] ba);
    a_chipselect = ar | aw;
    a_read       = ar;
    a_write      = aw;
    a_address    = aa;
    a_byteenable = abe;
    a_writedata  = awd;
    b_chipselect = br | bw;
    b_read       = br;
    b_write      = bw;
    b_address    = ba;
    b_byteenable = 4'hF;
    b_writedata  = 32'h0;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, 4'h0, 32'h0, 1'b0, 1'b0, '0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic              ar, aw, br;
    logic [ADDR_W-1:0] aa, ba;
    logic [BE_W-1:0]   abe;
    logic [31:0]       awd;
    logic              ewa, ewb, eva, evb;
    logic [31:0]       eda, edb;
  } vec_t;

  function automatic vec_t mk(input logic ar, input logic aw, input logic [ADDR_W-1:0] aa,
                              input logic [BE_W-1:0] abe, input logic [31:0] awd,
                              input logic br, input logic [ADDR_W-1:0] ba,
                              input logic ewa, input logic ewb, input logic eva,
                              input logic [31:0] eda, input logic evb, input logic [31:0] edb);
    vec_t v;
    v.ar = ar; v.aw = aw; v.aa = aa; v.abe = abe; v.awd = awd; v.br = br; v.ba = ba;
    v.ewa = ewa; v.ewb = ewb; v.eva = eva; v.eda = eda; v.evb = evb; v.edb = edb;
    return v;
  endfunction

  vec_t vt[18];
  logic [31:0] seqv[4];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //            ar  aw  addr   be    wdata         br  baddr   wa  wb  va  da            vb  db
    vt[0]  = mk(0, 1, 13'h010, 4'hF, 32'hDEADBEEF, 0, 13'h000, 0, 0, 0, 32'h00000000, 0, 32'h00000000);
    vt[1]  = mk(1, 0, 13'h010, 4'hF, 32'h0,        0, 13'h000, 0, 0, 1, 32'hDEADBEEF, 0, 32'h00000000);
    vt[2]  = mk(0, 0, 13'h000, 4'h0, 32'h0,        0, 13'h000, 0, 0, 0, 32'hDEADBEEF, 0, 32'h00000000);
    vt[3]  = mk(0, 1, 13'h020, 4'hF, 32'h11223344, 0, 13'h000, 0, 0, 0, 32'hDEADBEEF, 0, 32'h00000000);
    vt[4]  = mk(1, 0, 13'h010, 4'hF, 32'h0,        1, 13'h020, 0, 1, 1, 32'hDEADBEEF, 0, 32'h00000000);
    vt[5]  = mk(1, 0, 13'h020, 4'hF, 32'h0,        1, 13'h020, 1, 0, 0, 32'hDEADBEEF, 1, 32'h11223344);
    vt[6]  = mk(1, 0, 13'h020, 4'hF, 32'h0,        1, 13'h010, 0, 1, 1, 32'h11223344, 0, 32'h11223344);
    vt[7]  = mk(0, 1, 13'h020, 4'h5, 32'hAABBCCDD, 0, 13'h000, 0, 0, 0, 32'h11223344, 0, 32'h11223344);
    vt[8]  = mk(1, 0, 13'h020, 4'hF, 32'h0,        0, 13'h000, 0, 0, 1, 32'h11BB33DD, 0, 32'h11223344);
    vt[9]  = mk(0, 0, 13'h000, 4'h0, 32'h0,        1, 13'd6500, 0, 0, 0, 32'h11BB33DD, 1, 32'h00000000);
    vt[10] = mk(0, 1, 13'd100, 4'hF, 32'hCAFEF00D, 0, 13'h000, 0, 0, 0, 32'h11BB33DD, 0, 32'h00000000);
    vt[11] = mk(0, 1, 13'd6600, 4'hF, 32'h12345678, 0, 13'h000, 0, 0, 0, 32'h11BB33DD, 0, 32'h00000000);
    vt[12] = mk(1, 0, 13'd100, 4'hF, 32'h0,        0, 13'h000, 0, 0, 1, 32'hCAFEF00D, 0, 32'h00000000);
    vt[13] = mk(0, 1, 13'd100, 4'h0, 32'hFFFFFFFF, 0, 13'h000, 0, 0, 0, 32'hCAFEF00D, 0, 32'h00000000);
    vt[14] = mk(1, 0, 13'd100, 4'hF, 32'h0,        0, 13'h000, 0, 0, 1, 32'hCAFEF00D, 0, 32'h00000000);
    vt[15] = mk(0, 1, 13'h040, 4'hF, 32'h01020304, 1, 13'h010, 1, 0, 0, 32'hCAFEF00D, 1, 32'hDEADBEEF);
    vt[16] = mk(0, 1, 13'h040, 4'hF, 32'h01020304, 1, 13'h040, 0, 1, 0, 32'hCAFEF00D, 0, 32'hDEADBEEF);
    vt[17] = mk(0, 0, 13'h000, 4'h0, 32'h0,        1, 13'h040, 0, 0, 0, 32'hCAFEF00D, 1, 32'h01020304);

    reset_n = 1'b0;
    clken   = 1'b1;
    idle();
    step();
    step();
    chk("reset a_vld0", a_vld0, 0);
    chk("reset b_vld0", b_vld0, 0);
    chk("reset a_rd0", a_rd0, 0);
    chk("reset b_rd0", b_rd0, 0);
    chk("reset a_vld1", a_vld1, 0);
    chk("reset b_rd1", b_rd1, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      drive(vt[i].ar, vt[i].aw, vt[i].aa, vt[i].abe, vt[i].awd, vt[i].br, 1'b0, vt[i].ba);
      #1;
      chk($sformatf("vec%0d a_waitrequest", i), a_wait0, vt[i].ewa);
      chk($sformatf("vec%0d b_waitrequest", i), b_wait0, vt[i].ewb);
      step();
      chk($sformatf("vec%0d a_readdatavalid", i), a_vld0, vt[i].eva);
      chk($sformatf("vec%0d b_readdatavalid", i), b_vld0, vt[i].evb);
      chk($sformatf("vec%0d a_readdata", i), a_rd0, vt[i].eda);
      chk($sformatf("vec%0d b_readdata", i), b_rd0, vt[i].edb);
    end

    // Back-to-back reads: latency 1 on dut0, latency 2 on dut1.
    for (int i = 0; i < 4; i++) begin
      seqv[i] = 32'h50000000 + 32'(i) * 32'h01010101;
      drive(1'b0, 1'b1, 13'(i), 4'hF, seqv[i], 1'b0, 1'b0, '0);
      step();
    end
    for (int i = 0; i < 7; i++) begin
      if (i < 4) drive(1'b1, 1'b0, 13'(i), 4'hF, 32'h0, 1'b0, 1'b0, '0);
      else idle();
      #1;
      chk($sformatf("b2b c%0d dut1 a_vld", i), a_vld1, (i >= 2 && i <= 5));
      if (i >= 2 && i <= 5) chk($sformatf("b2b c%0d dut1 a_rd", i), a_rd1, seqv[i-2]);
      chk($sformatf("b2b c%0d dut0 a_vld", i), a_vld0, (i >= 1 && i <= 4));
      if (i >= 1 && i <= 4) chk($sformatf("b2b c%0d dut0 a_rd", i), a_rd0, seqv[i-1]);
      step();
    end

    // Read accepted, then clken low for three cycles.
    drive(1'b1, 1'b0, 13'h010, 4'hF, 32'h0, 1'b0, 1'b0, '0);
    step();
    clken = 1'b0;
    drive(1'b1, 1'b0, 13'h020, 4'hF, 32'h0, 1'b0, 1'b0, '0);
    #1;
    chk("clken-low a_waitrequest", a_wait0, 1);
    chk("clken-low c1 a_vld0", a_vld0, 0);
    step();
    idle();
    for (int i = 2; i < 4; i++) begin
      chk($sformatf("clken-low c%0d a_vld0", i), a_vld0, 0);
      chk($sformatf("clken-low c%0d a_vld1", i), a_vld1, 0);
      step();
    end
    clken = 1'b1;
    #1;
    chk("clken-back c4 a_vld0", a_vld0, 1);
    chk("clken-back c4 a_rd0", a_rd0, 32'hDEADBEEF);
    chk("clken-back c4 a_vld1", a_vld1, 0);
    step();
    chk("clken-back c5 a_vld0", a_vld0, 0);
    chk("clken-back c5 a_vld1", a_vld1, 1);
    chk("clken-back c5 a_rd1", a_rd1, 32'hDEADBEEF);
    step();
    chk("clken-back c6 a_vld1", a_vld1, 0);

    // Reset pulsed with a read in flight; pointer was at port b beforehand.
    drive(1'b1, 1'b0, 13'h010, 4'hF, 32'h0, 1'b0, 1'b0, '0);
    step();
    idle();
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid-reset a_vld0", a_vld0, 0);
    chk("mid-reset a_rd0", a_rd0, 0);
    chk("mid-reset a_vld1", a_vld1, 0);
    #2;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("post-reset c%0d a_vld0", i), a_vld0, 0);
      chk($sformatf("post-reset c%0d a_vld1", i), a_vld1, 0);
      chk($sformatf("post-reset c%0d b_vld1", i), b_vld1, 0);
    end
    drive(1'b1, 1'b0, 13'h010, 4'hF, 32'h0, 1'b1, 1'b0, 13'h020);
    #1;
    chk("post-reset pair a_waitrequest", a_wait0, 0);
    chk("post-reset pair b_waitrequest", b_wait0, 1);
    step();
    idle();
    chk("post-reset pair a_vld0", a_vld0, 1);
    chk("post-reset pair a_rd0", a_rd0, 32'hDEADBEEF);
    chk("post-reset pair b_vld0", b_vld0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
